// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM encoding and digit width.
package nibble_serial_addsub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_addsub_four_adder.sv
// Four-bit ripple-carry adder; also exposes the carry into bit 3 for signed-overflow detection.
module four_adder
    import nibble_serial_addsub_pkg::*;
(
    input  logic             Cin,
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    output logic [NIB_W-1:0] S,
    output logic             cout,
    output logic             C3
);

    always_comb begin
        logic cy;
        cy = Cin;
        C3 = 1'b0;
        for (int i = 0; i < NIB_W; i++) begin
            if (i == NIB_W - 1) C3 = cy;
            S[i] = A[i] ^ B[i] ^ cy;
            cy   = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
        end
        cout = cy;
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract: one 4-bit digit per cycle through a single shared ripple adder,
// with valid/ready handshakes on both sides and back-to-back accept from DONE.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int               IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBBLES - 1);

    state_t                         state;
    logic [NIBBLES-1:0][NIB_W-1:0]  a_q;
    logic [NIBBLES-1:0][NIB_W-1:0]  b_q;
    logic [NIBBLES-1:0][NIB_W-1:0]  sum_q;
    logic [NIBBLES-1:0][NIB_W-1:0]  sum_next;
    logic                           op_q;
    logic                           carry;
    logic [IDX_W-1:0]               idx;
    logic [NIB_W-1:0]               nib_s;
    logic                           nib_cout;
    logic                           nib_c3;
    logic                           accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign sum       = sum_q;

    // Subtraction is A + ~B + 1: B is inverted here and the +1 comes from the seeded carry.
    four_adder u_adder (
        .Cin  (carry),
        .A    (a_q[idx]),
        .B    (b_q[idx] ^ {NIB_W{op_q}}),
        .S    (nib_s),
        .cout (nib_cout),
        .C3   (nib_c3)
    );

    always_comb begin
        sum_next      = sum_q;
        sum_next[idx] = nib_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            sum_q <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        carry <= op;
                        idx   <= '0;
                        state <= RUN;
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[idx] <= nib_s;
                    carry      <= nib_cout;
                    // Flags are captured only on the last digit; the index stops there.
                    if (idx == LAST) begin
                        cout  <= nib_cout;
                        ovf   <= nib_cout ^ nib_c3;
                        zero  <= (sum_next == '0);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub with an arithmetic reference model and per-cycle compare.
module tb_nibble_serial_addsub;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain two's-complement arithmetic on the whole word.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mop);
        logic [W:0]   t;
        logic [W-1:0] bb;
        logic [W-1:0] s;
        logic         v;
        bb = mb ^ {W{mop}};
        t  = {1'b0, ma} + {1'b0, bb} + (W+1)'(mop);
        s  = t[W-1:0];
        v  = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
        return {s, t[W], v, (s == '0)};
    endfunction

    int           run_left = 0;
    logic         m_done = 1'b0;
    logic [W+2:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_left <= 0;
            m_done   <= 1'b0;
        end else begin
            if (in_valid && run_left == 0 && (!m_done || out_ready)) begin
                run_left <= NIBBLES;
                m_exp    <= model(a, b, op);
            end else if (run_left > 0) begin
                run_left <= run_left - 1;
            end
            if (run_left == 1)
                m_done <= 1'b1;
            else if (m_done && out_ready)
                m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        end else begin
            check("mdl_out_valid", 32'(out_valid), 32'(m_done));
            check("mdl_in_ready", 32'(in_ready),
                  32'((run_left == 0) && (!m_done || out_ready)));
            if (m_done) begin
                check("mdl_sum", 32'(sum), 32'(m_exp[W+2:3]));
                check("mdl_cout", 32'(cout), 32'(m_exp[2]));
                check("mdl_ovf", 32'(ovf), 32'(m_exp[1]));
                check("mdl_zero", 32'(zero), 32'(m_exp[0]));
            end
        end
    end

    // Waits for out_valid (bounded) and returns cycles counted including the accept cycle.
    task automatic wait_result(output int cycles);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        cycles = lat + 1;
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                          input logic [W-1:0] es, input logic ec, input logic ev, input logic ez);
        int cyc;
        a = ta; b = tb; op = top; in_valid = 1'b1;
        #1;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(cyc);
        check("latency", 32'(cyc), 32'(NIBBLES + 1));
        check("lit_sum", 32'(sum), 32'(es));
        check("lit_flags", {29'd0, cout, ovf, zero}, {29'd0, ec, ev, ez});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("consumed", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        #1;
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Backpressure with an ignored request, then back-to-back accept.
        a = 16'h00FF; b = 16'h0F01; op = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(cyc);
        a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h1000);
            @(posedge clk);
            #1;
        end
        check("bp_hold_sum", 32'(sum), 32'h1000);
        a = 16'hAAAA; b = 16'h5555; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_running", 32'(out_valid), 32'd0);
        wait_result(cyc);
        check("b2b_latency", 32'(cyc), 32'(NIBBLES + 1));
        check("b2b_sum", 32'(sum), 32'hFFFF);
        check("b2b_flags", {29'd0, cout, ovf, zero}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during the second RUN cycle.
        a = 16'h1234; b = 16'h4321; op = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
